// File: rtl/ps2_kb_receiver.sv
// ps2_kb_receiver: PS/2 keyboard front end.
// Synchronizes and deglitches the raw PS/2 clock/data pads, deserializes
// 11-bit device-to-host frames (start, 8 data LSB first, parity, stop) and
// keeps the last two accepted bytes as {previous, newest} on KBBuffer.
// Key_Valid pulses for each accepted byte; Frame_Err pulses for each rejected
// frame (bad start, bad stop, inter-edge timeout, or parity when enabled).
// Optional build macro PS2_PARITY_CHECK_EN: when defined, frames must carry
// odd parity over the 8 data bits plus the parity bit; when undefined the
// parity bit is sampled and ignored.
module ps2_kb_receiver #(
    parameter int unsigned FILTER_LEN     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned TIMEOUT_W      = 17
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PS2_CLK,
    input  logic        PS2_DATA,
    output logic [15:0] KBBuffer,
    output logic        Key_Valid,
    output logic        Frame_Err
);

    localparam int unsigned          FLT_W     = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam logic [FLT_W-1:0]     FLT_LAST  = FLT_W'(FILTER_LEN - 1);
    localparam logic [TIMEOUT_W-1:0] TMO_LIMIT = TIMEOUT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers (idle line is high)
    // ------------------------------------------------------------------
    logic [1:0] ps2c_sync_q, ps2c_sync_d;
    logic [1:0] ps2d_sync_q, ps2d_sync_d;

    // Shift each raw pad through two flops
    always_comb begin
        ps2c_sync_d = {ps2c_sync_q[0], PS2_CLK};
        ps2d_sync_d = {ps2d_sync_q[0], PS2_DATA};
    end

    // Synchronizer registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            ps2c_sync_q <= '1;
            ps2d_sync_q <= '1;
        end else begin
            ps2c_sync_q <= ps2c_sync_d;
            ps2d_sync_q <= ps2d_sync_d;
        end
    end

    logic ps2c_s;
    logic ps2d_s;
    assign ps2c_s = ps2c_sync_q[1];
    assign ps2d_s = ps2d_sync_q[1];

    // ------------------------------------------------------------------
    // Clock deglitch filter and falling-edge detect
    // ------------------------------------------------------------------
    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic             flt_clk_q, flt_clk_d;
    logic             flt_prev_q, flt_prev_d;
    logic             fall;

    // Filtered clock only follows the synced clock after FILTER_LEN stable cycles
    always_comb begin
        flt_cnt_d  = '0;
        flt_clk_d  = flt_clk_q;
        flt_prev_d = flt_clk_q;
        if (ps2c_s != flt_clk_q) begin
            if (flt_cnt_q == FLT_LAST) begin
                flt_clk_d = ps2c_s;
            end else begin
                flt_cnt_d = flt_cnt_q + 1'b1;
            end
        end
    end

    // Filter registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            flt_cnt_q  <= '0;
            flt_clk_q  <= 1'b1;
            flt_prev_q <= 1'b1;
        end else begin
            flt_cnt_q  <= flt_cnt_d;
            flt_clk_q  <= flt_clk_d;
            flt_prev_q <= flt_prev_d;
        end
    end

    // The data line is sampled from its synchronizer on this same cycle
    assign fall = flt_prev_q & ~flt_clk_q;

    // ------------------------------------------------------------------
    // Frame deserializer
    // ------------------------------------------------------------------
    state_t                 state_q, state_d;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   parity_q, parity_d;
    logic [TIMEOUT_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic [15:0]            kb_q, kb_d;
    logic                   key_valid_q, key_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   parity_ok;

`ifdef PS2_PARITY_CHECK_EN
    assign parity_ok = ^{shift_q, parity_q};
`else
    logic parity_unused;
    assign parity_unused = parity_q;
    assign parity_ok     = 1'b1;
`endif

    // Next-state, shift, timeout and registered output pulses
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        parity_d    = parity_q;
        tmo_cnt_d   = tmo_cnt_q;
        kb_d        = kb_q;
        key_valid_d = 1'b0;
        frame_err_d = 1'b0;

        if (state_q == IDLE || fall) begin
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (fall) begin
                    if (!ps2d_s) begin
                        state_d   = DATA;
                        bit_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d   = {ps2d_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_d = ps2d_s;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_d = IDLE;
                    if (ps2d_s && parity_ok) begin
                        kb_d        = {kb_q[7:0], shift_q};
                        key_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A falling edge on the expiry cycle wins, since it restarts the count
        if (state_q != IDLE && !fall && tmo_cnt_q == TMO_LIMIT) begin
            state_d     = IDLE;
            bit_cnt_d   = '0;
            tmo_cnt_d   = '0;
            frame_err_d = 1'b1;
        end
    end

    // Deserializer and output registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            parity_q    <= 1'b0;
            tmo_cnt_q   <= '0;
            kb_q        <= '0;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            parity_q    <= parity_d;
            tmo_cnt_q   <= tmo_cnt_d;
            kb_q        <= kb_d;
            key_valid_q <= key_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign KBBuffer  = kb_q;
    assign Key_Valid = key_valid_q;
    assign Frame_Err = frame_err_q;

endmodule

// File: doc/ps2_kb_receiver.md
Name: ps2_kb_receiver

Overview:
- PS/2 keyboard front end; sits directly upstream of the keyboard command controller.
- Synchronizes and deglitches the raw PS/2 clock/data lines, then deserializes 11-bit device-to-host frames.
- Presents the last two received scan-code bytes as a 16-bit history word: older byte high, newest byte low. A break sequence therefore reads F0xx.
- Flags each accepted byte and each rejected frame.

Parameters:
- FILTER_LEN, 8: CLK cycles PS2_CLK must hold a new level before the filtered clock changes.
- TIMEOUT_CYCLES, 100000: idle CLK cycles between falling edges before an in-progress frame is aborted (1 ms at 100 MHz).
- TIMEOUT_W, 17: width of the timeout counter; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  system clock, single clock domain.
- RESET  in  1  asynchronous, active-high reset.
- PS2_CLK  in  1  raw PS/2 clock from the pad; asynchronous.
- PS2_DATA  in  1  raw PS/2 data from the pad; asynchronous.
- KBBuffer  out  16  {previous byte, newest byte}.
- Key_Valid  out  1  one-cycle pulse when KBBuffer updates.
- Frame_Err  out  1  one-cycle pulse when a frame is rejected.

Behaviour:
- Reset values: KBBuffer=16'h0000, Key_Valid=0, Frame_Err=0. Synchronizer flops and filtered clock reset to 1 (idle line). FSM resets to IDLE; shift register, bit counter and timeout counter reset to 0.
- Input sync: two-flop synchronizer on each of PS2_CLK and PS2_DATA.
- Clock filter:
  - A counter increments while the synced PS2_CLK differs from the filtered clock, and clears otherwise.
  - When the count reaches FILTER_LEN-1, the filtered clock takes the synced value.
  - A falling edge is detected on the filtered clock. PS2_DATA is sampled from its synchronizer on that same cycle.
- FSM states: IDLE, DATA, PARITY, STOP. Actions on each falling edge:
  - IDLE: data=0 -> DATA, bit count=0. Data=1 -> pulse Frame_Err, stay IDLE.
  - DATA: shift data in LSB first (new bit into bit 7, shift right). After the 8th bit -> PARITY.
  - PARITY: store the parity bit -> STOP.
  - STOP: data=1 and parity acceptable -> KBBuffer <= {KBBuffer[7:0], byte}, Key_Valid=1. Otherwise Frame_Err=1 and KBBuffer holds. Always -> IDLE.
- Latency: KBBuffer and Key_Valid are both registered and change together, 1 CLK after the cycle the stop-bit falling edge is detected.
- Duplicates: KBBuffer updates even when the new byte equals the current low byte (typematic repeat). Key_Valid still pulses.
- Timeout:
  - In any state other than IDLE, the counter increments every cycle and clears on each falling edge.
  - Reaching TIMEOUT_CYCLES -> pulse Frame_Err, go to IDLE, clear the bit counter. KBBuffer is untouched.
  - In IDLE the counter is held at 0.
- Key_Valid and Frame_Err are never asserted in the same cycle.
- Reset mid-frame: the partial frame is discarded and KBBuffer returns to 0000.

Optional Feature:
- PS2_PARITY_CHECK_EN defined: in STOP, the frame is accepted only if the XOR of the 8 data bits and the parity bit is 1 (odd parity). A mismatch pulses Frame_Err and drops the byte.
- Undefined: the parity bit is sampled and ignored. Only the start bit, stop bit and timeout gate acceptance.

Test Plan:
- Reset, then send 0x1C with parity 0 -> one Key_Valid pulse, KBBuffer=16'h001C, Frame_Err stays 0.
- Send 0xF0 (parity 1) then 0x1C -> KBBuffer=16'h1CF0 after the first frame, 16'hF01C after the second; exactly two Key_Valid pulses.
- Send 0x5A with stop bit 0 -> one Frame_Err pulse, no Key_Valid, KBBuffer unchanged. Inject a 3-cycle PS2_CLK low glitch (FILTER_LEN=8) -> no bit sampled, FSM stays in IDLE.
- Send start + 4 data bits, then hold the lines high for TIMEOUT_CYCLES -> one Frame_Err pulse and return to IDLE. A following good 0x5A (parity 1) gives KBBuffer low byte = 8'h5A.
- Send 0x05 with wrong parity 0 -> with PS2_PARITY_CHECK_EN: Frame_Err pulse, KBBuffer unchanged. Without it: Key_Valid pulse, low byte = 8'h05.
- Assert RESET after the 6th bit of a frame -> KBBuffer=0000, all pulses 0. A subsequent full frame 0x16 gives KBBuffer=16'h0016.
